rriot_timer: RTL and testbench

- Interval timer for the 6530 RRIOT core. It sits on the same internal bus slice as the port I/O block and shares its `enable`/`we_n`/`A`/`DI`/`DO`/`OE` handshake.
- Provides an 8-bit down-counter with selectable prescale (1/8/64/1024) and an underflow interrupt flag.
- Its `irq_n` output feeds the port-B stage, which muxes it onto PB7.

---
 rtl/rriot_timer_if.sv | 21 ++
 rtl/rriot_timer.sv | 110 +++++++++++
 tb/tb_rriot_timer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rriot_timer_if.sv
// Bus slice shared by the RRIOT timer and port blocks: select/strobe/address/data
// plus the timer's read-enable and interrupt outputs.
interface rriot_timer_if;
    logic       enable;
    logic       we_n;
    logic [3:0] A;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       OE;
    logic       irq_n;

    modport master (
        output enable, we_n, A, DI,
        input  DO, OE, irq_n
    );

    modport slave (
        input  enable, we_n, A, DI,
        output DO, OE, irq_n
    );
endinterface

// File: rtl/rriot_timer.sv
// 6530 RRIOT interval timer: 8-bit down-counter with 1/8/64/1024 prescale, an
// underflow flag, and divide-by-1 post-underflow running until the next write/read.
module rriot_timer (
    input  logic         clk,
    input  logic         rst_n,
    rriot_timer_if.slave bus
);
    logic [7:0] r_count,   w_count_nxt;
    logic [1:0] r_div_sel, w_div_sel_nxt;
    logic [9:0] r_presc,   w_presc_nxt;
    logic       r_irq_en,  w_irq_en_nxt;
    logic       r_flag,    w_flag_nxt;
    logic       r_post,    w_post_nxt;
    logic       r_armed,   w_armed_nxt;
    logic [7:0] r_rd_data, w_rd_data_nxt;

    logic w_acc, w_wr, w_rd_tmr, w_rd_flg, w_dec, w_uflow;

    function automatic logic [9:0] f_reload(input logic [1:0] i_sel);
        case (i_sel)
            2'b00:   return 10'd0;
            2'b01:   return 10'd7;
            2'b10:   return 10'd63;
            default: return 10'd1023;
        endcase
    endfunction

    assign w_acc    = bus.enable & bus.A[2];
    assign w_wr     = w_acc & ~bus.we_n;
    assign w_rd_tmr = w_acc & bus.we_n & ~bus.A[0];
    assign w_rd_flg = w_acc & bus.we_n & bus.A[0];
    assign w_dec    = r_armed & (r_post | (r_presc == 10'd0));
    assign w_uflow  = w_dec & (r_count == 8'h00);

    always_comb begin
        w_count_nxt   = r_count;
        w_div_sel_nxt = r_div_sel;
        w_presc_nxt   = r_presc;
        w_irq_en_nxt  = r_irq_en;
        w_flag_nxt    = r_flag;
        w_post_nxt    = r_post;
        w_armed_nxt   = r_armed;
        w_rd_data_nxt = r_rd_data;

        if (w_wr) begin
            w_count_nxt   = bus.DI;
            w_div_sel_nxt = bus.A[1:0];
            w_irq_en_nxt  = bus.A[3];
            w_flag_nxt    = 1'b0;
            w_post_nxt    = 1'b0;
            w_armed_nxt   = 1'b1;
            w_presc_nxt   = f_reload(bus.A[1:0]);
        end else begin
            if (w_rd_tmr) begin
                w_rd_data_nxt = r_count;
                w_flag_nxt    = 1'b0;
                w_irq_en_nxt  = bus.A[3];
            end
            if (w_rd_flg) begin
                w_rd_data_nxt = {r_flag, 7'b0};
            end

            // Underflow overrides the read's flag clear and post-mode exit.
            if (w_uflow) begin
                w_count_nxt = 8'hFF;
                w_flag_nxt  = 1'b1;
                w_post_nxt  = 1'b1;
                w_presc_nxt = f_reload(r_div_sel);
            end else if (w_rd_tmr && r_post) begin
                w_post_nxt  = 1'b0;
                w_presc_nxt = f_reload(r_div_sel);
            end else if (r_armed) begin
                if (r_post) begin
                    w_count_nxt = r_count - 8'd1;
                end else if (r_presc == 10'd0) begin
                    w_count_nxt = r_count - 8'd1;
                    w_presc_nxt = f_reload(r_div_sel);
                end else begin
                    w_presc_nxt = r_presc - 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= 8'h00;
            r_div_sel <= 2'b00;
            r_presc   <= 10'd0;
            r_irq_en  <= 1'b0;
            r_flag    <= 1'b0;
            r_post    <= 1'b0;
            r_armed   <= 1'b0;
            r_rd_data <= 8'h00;
        end else begin
            r_count   <= w_count_nxt;
            r_div_sel <= w_div_sel_nxt;
            r_presc   <= w_presc_nxt;
            r_irq_en  <= w_irq_en_nxt;
            r_flag    <= w_flag_nxt;
            r_post    <= w_post_nxt;
            r_armed   <= w_armed_nxt;
            r_rd_data <= w_rd_data_nxt;
        end
    end

    assign bus.OE    = bus.enable & bus.we_n & bus.A[2];
    assign bus.DO    = bus.OE ? r_rd_data : 8'h00;
    assign bus.irq_n = ~(r_flag & r_irq_en);
endmodule

// File: tb/tb_rriot_timer.sv
// Bench for rriot_timer: directed scenarios plus random bus traffic against a
// model that schedules decrements by absolute edge number.
module tb_rriot_timer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rriot_timer_if bus ();

    rriot_timer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state: next decrement is scheduled as an absolute edge number.
    logic [7:0] m_count, m_rd;
    int         m_n, m_e, m_next;
    bit         m_flag, m_post, m_ien, m_armed;
    bit         cur_en, cur_we;
    logic [3:0] cur_a;

    function automatic int div_of(input logic [1:0] s);
        case (s)
            2'd0:    return 1;
            2'd1:    return 8;
            2'd2:    return 64;
            default: return 1024;
        endcase
    endfunction

    function automatic logic exp_oe();
        return cur_en && cur_we && cur_a[2];
    endfunction

    function automatic logic [7:0] exp_do();
        return exp_oe() ? m_rd : 8'h00;
    endfunction

    function automatic logic exp_irq_n();
        return !(m_flag && m_ien);
    endfunction

    task automatic model_reset();
        m_count = 8'h00; m_rd = 8'h00; m_n = 1; m_next = 0;
        m_flag = 0; m_post = 0; m_ien = 0; m_armed = 0;
    endtask

    task automatic model_edge(input bit en, input bit we, input logic [3:0] a,
                              input logic [7:0] di);
        bit acc, rd_t, rd_f, dec, post_old;
        m_e++;
        acc      = en && a[2];
        rd_t     = acc && we && !a[0];
        rd_f     = acc && we && a[0];
        dec      = m_armed && (m_e == m_next);
        post_old = m_post;
        if (acc && !we) begin
            m_count = di; m_n = div_of(a[1:0]); m_ien = a[3];
            m_flag = 0; m_post = 0; m_armed = 1; m_next = m_e + m_n;
        end else begin
            if (rd_t) begin m_rd = m_count; m_flag = 0; m_ien = a[3]; end
            if (rd_f) m_rd = {m_flag, 7'b0};
            if (dec && m_count == 8'h00) begin
                m_count = 8'hFF; m_flag = 1; m_post = 1; m_next = m_e + 1;
            end else if (rd_t && post_old) begin
                m_post = 0; m_next = m_e + m_n;
            end else if (dec) begin
                m_count = m_count - 8'd1;
                m_next  = m_e + (m_post ? 1 : m_n);
            end
        end
    endtask

    task automatic step(input bit en, input bit we, input logic [3:0] a, input logic [7:0] di);
        @(negedge clk);
        bus.enable = en; bus.we_n = we; bus.A = a; bus.DI = di;
        cur_en = en; cur_we = we; cur_a = a;
        @(posedge clk);
        model_edge(en, we, a, di);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 4'h0, 8'h00);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.enable = 0; bus.we_n = 1; bus.A = 4'h0; bus.DI = 8'h00;
        cur_en = 0; cur_we = 1; cur_a = 4'h0;
        model_reset();
        #23;
        checks++;
        if ({dut.r_count, bus.OE, bus.irq_n, bus.DO} !== {8'h00, 1'b0, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: count=%h OE=%b irq_n=%b DO=%h, want 00 0 1 00",
                     dut.r_count, bus.OE, bus.irq_n, bus.DO);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            idle();
            checks++;
            if ({dut.r_count, dut.r_flag, bus.irq_n, bus.OE} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL idle_after_reset[%0d]: count=%h flag=%b irq_n=%b OE=%b, want 00 0 1 0",
                         i, dut.r_count, dut.r_flag, bus.irq_n, bus.OE);
            end
        end
        step(1'b1, 1'b1, 4'b0101, 8'h00);
        checks++;
        if (bus.DO !== 8'h00 || bus.OE !== 1'b1) begin
            errors++;
            $display("FAIL reset_flag_read: DO=%h OE=%b, want 00 1", bus.DO, bus.OE);
        end
    endtask

    task automatic test_div8_irq();
        logic [7:0] want;
        step(1'b1, 1'b0, 4'b1101, 8'h03);
        for (int e = 1; e <= 40; e++) begin
            idle();
            case (e)
                8:  want = 8'h02;
                16: want = 8'h01;
                24: want = 8'h00;
                32: want = 8'hFF;
                33: want = 8'hFE;
                default: want = m_count;
            endcase
            checks++;
            if (dut.r_count !== want || dut.r_count !== m_count) begin
                errors++;
                $display("FAIL div8_count E%0d: got %h, want %h", e, dut.r_count, want);
            end
            if (e == 32) begin
                checks++;
                if (dut.r_flag !== 1'b1 || bus.irq_n !== 1'b0) begin
                    errors++;
                    $display("FAIL div8_uflow_irq: flag=%b irq_n=%b, want 1 0",
                             dut.r_flag, bus.irq_n);
                end
            end
        end
        // Count is F7 entering this edge; reading leaves post mode.
        step(1'b1, 1'b1, 4'b1100, 8'h00);
        checks++;
        if ({bus.DO, dut.r_flag, bus.irq_n, dut.r_irq_en} !== {8'hF7, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL div8_read: DO=%h flag=%b irq_n=%b irq_en=%b, want F7 0 1 1",
                     bus.DO, dut.r_flag, bus.irq_n, dut.r_irq_en);
        end
        repeat (7) idle();
        checks++;
        if (dut.r_count !== 8'hF7) begin
            errors++;
            $display("FAIL div8_resume_hold: count=%h, want F7", dut.r_count);
        end
        idle();
        checks++;
        if (dut.r_count !== 8'hF6) begin
            errors++;
            $display("FAIL div8_resume_dec: count=%h, want F6", dut.r_count);
        end
    endtask

    task automatic test_div1_noirq();
        step(1'b1, 1'b0, 4'b0100, 8'h00);
        idle();
        checks++;
        if ({dut.r_flag, dut.r_count, bus.irq_n} !== {1'b1, 8'hFF, 1'b1}) begin
            errors++;
            $display("FAIL div1_uflow: flag=%b count=%h irq_n=%b, want 1 FF 1",
                     dut.r_flag, dut.r_count, bus.irq_n);
        end
        step(1'b1, 1'b1, 4'b0101, 8'h00);
        checks++;
        if (bus.DO !== 8'h80 || dut.r_flag !== 1'b1) begin
            errors++;
            $display("FAIL flag_read: DO=%h flag=%b, want 80 1", bus.DO, dut.r_flag);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 4'b0111, 8'h05);
        repeat (100) idle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({dut.r_count, dut.r_flag, bus.irq_n, bus.DO} !== {8'h00, 1'b0, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL async_reset: count=%h flag=%b irq_n=%b DO=%h, want 00 0 1 00",
                     dut.r_count, dut.r_flag, bus.irq_n, bus.DO);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (1100) idle();
        checks++;
        if (dut.r_count !== 8'h00 || dut.r_flag !== 1'b0) begin
            errors++;
            $display("FAIL disarmed_after_reset: count=%h flag=%b, want 00 0",
                     dut.r_count, dut.r_flag);
        end
    endtask

    task automatic test_simultaneous();
        int guard;
        step(1'b1, 1'b0, 4'b1100, 8'h00);
        guard = 0;
        while (!(m_post && m_count == 8'h00) && guard < 2000) begin
            idle();
            guard++;
        end
        checks++;
        if (guard >= 2000) begin
            errors++;
            $display("FAIL post_zero_timeout: never reached count 00 in post mode");
        end
        step(1'b1, 1'b1, 4'b1100, 8'h00);
        checks++;
        if ({bus.DO, dut.r_flag, bus.irq_n, dut.r_count} !== {8'h00, 1'b1, 1'b0, 8'hFF}) begin
            errors++;
            $display("FAIL read_vs_uflow: DO=%h flag=%b irq_n=%b count=%h, want 00 1 0 FF",
                     bus.DO, dut.r_flag, bus.irq_n, dut.r_count);
        end
        step(1'b1, 1'b0, 4'b1100, 8'h00);
        step(1'b1, 1'b0, 4'b0100, 8'h5A);
        checks++;
        if ({dut.r_flag, dut.r_count, bus.irq_n} !== {1'b0, 8'h5A, 1'b1}) begin
            errors++;
            $display("FAIL write_vs_uflow: flag=%b count=%h irq_n=%b, want 0 5A 1",
                     dut.r_flag, dut.r_count, bus.irq_n);
        end
    endtask

    task automatic test_random();
        int r, s;
        bit en, we;
        logic [3:0] a;
        logic [7:0] di;
        for (int i = 0; i < 4000; i++) begin
            r  = $urandom_range(0, 99);
            en = 1; we = 1; a = 4'h0; di = 8'h00;
            if (r < 4) begin
                s  = $urandom_range(0, 9);
                we = 0;
                a  = {1'($urandom), 1'b1, (s < 5) ? 2'd0 : (s < 8) ? 2'd1 : (s < 9) ? 2'd2 : 2'd3};
                di = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            end else if (r < 10) begin
                a = {1'($urandom), 1'b1, 1'($urandom), 1'b0};
            end else if (r < 16) begin
                a = {1'($urandom), 1'b1, 1'($urandom), 1'b1};
            end else if (r < 22) begin
                en = 1'($urandom);
                we = 1'($urandom);
                a  = 4'($urandom);
                if (en) a[2] = 1'b0;
                di = 8'($urandom);
            end else begin
                en = 0;
            end
            step(en, we, a, di);
            checks++;
            if ({bus.DO, bus.OE, bus.irq_n, dut.r_count} !==
                {exp_do(), exp_oe(), exp_irq_n(), m_count}) begin
                errors++;
                $display("FAIL random[%0d]: DO=%h OE=%b irq_n=%b count=%h, want %h %b %b %h",
                         i, bus.DO, bus.OE, bus.irq_n, dut.r_count,
                         exp_do(), exp_oe(), exp_irq_n(), m_count);
            end
        end
    endtask

    initial begin
        m_e = 0;
        test_reset();
        test_div8_irq();
        test_div1_noirq();
        test_async_reset();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
